// File: rtl/pixel_packer_pkg.sv
// Shared constants and types for the monochrome pixel packer.
// Geometry defaults describe the Mac SE frame buffer (512x342, 16-pixel words).
package pixel_packer_pkg;

    localparam int MAC_SE_WIDTH          = 512;
    localparam int MAC_SE_HEIGHT         = 342;
    localparam int MAC_SE_WORD_W         = 16;
    localparam int MAC_SE_WORDS_PER_LINE = MAC_SE_WIDTH / MAC_SE_WORD_W;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } acc_state_e;

endpackage

// File: rtl/pixel_packer_word_fifo.sv
// Small circular-buffer FIFO for packed frame-buffer words.
// Head is forced to zero while empty so the outputs read zero after reset.
module word_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic             drop_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, do_pop, do_push;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        valid_o = (count_q != '0);
        do_pop  = pop_i && valid_o;
        // A full queue still accepts a push when the head leaves the same cycle.
        do_push = push_i && (!full || do_pop);
        drop_o  = push_i && !do_push;
        head_o  = valid_o ? mem_q[rd_q] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_pop)  rd_q <= bump(rd_q);
            if (do_push) wr_q <= bump(wr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; entries are only visible through head_o once counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/pixel_packer.sv
// Packs scaled 1-bit pixels into WORD_W-pixel frame-buffer words with write masks,
// queuing completed words in a small FIFO toward the frame-buffer port.
module pixel_packer #(
    parameter int OUTPUT_WIDTH  = pixel_packer_pkg::MAC_SE_WIDTH,
    parameter int OUTPUT_HEIGHT = pixel_packer_pkg::MAC_SE_HEIGHT,
    parameter int WORD_W        = pixel_packer_pkg::MAC_SE_WORD_W,
    parameter int FIFO_DEPTH    = 2,
    localparam int X_W    = $clog2(OUTPUT_WIDTH),
    localparam int Y_W    = $clog2(OUTPUT_HEIGHT),
    localparam int ADDR_W = $clog2(OUTPUT_WIDTH * OUTPUT_HEIGHT / WORD_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_we,
    input  logic              pix_val,
    input  logic [X_W-1:0]    pix_x,
    input  logic [Y_W-1:0]    pix_y,
    input  logic              flush,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [ADDR_W-1:0] word_addr,
    output logic [WORD_W-1:0] word_data,
    output logic [WORD_W-1:0] word_mask,
    output logic              overflow
);

    import pixel_packer_pkg::*;

    localparam int WPL       = OUTPUT_WIDTH / WORD_W;
    localparam int OFF_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int PAYLOAD_W = ADDR_W + 2 * WORD_W;

    acc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d, mask_q, mask_d;
    logic              overflow_q;

    logic              pix_ok, pix_last, same_addr;
    logic [ADDR_W-1:0] pix_addr;
    logic [OFF_W-1:0]  pix_off;
    logic [WORD_W-1:0] pix_bit, pix_data;

    logic              emit, fifo_drop;
    logic [ADDR_W-1:0] emit_addr;
    logic [WORD_W-1:0] emit_data, emit_mask;

    always_comb begin
        pix_ok    = pix_we && (int'(pix_x) < OUTPUT_WIDTH) && (int'(pix_y) < OUTPUT_HEIGHT);
        pix_addr  = ADDR_W'(pix_y) * ADDR_W'(WPL) + ADDR_W'(pix_x / X_W'(WORD_W));
        pix_off   = OFF_W'(pix_x % X_W'(WORD_W));
        // Leftmost pixel of a word lands in the MSB.
        pix_bit   = WORD_W'(1) << (OFF_W'(WORD_W - 1) - pix_off);
        pix_last  = (pix_off == OFF_W'(WORD_W - 1));
        pix_data  = pix_val ? pix_bit : '0;
        same_addr = (pix_addr == addr_q);
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mask_d    = mask_q;
        emit      = 1'b0;
        emit_addr = addr_q;
        emit_data = data_q;
        emit_mask = mask_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pix_ok) begin
                    addr_d = pix_addr;
                    data_d = pix_data;
                    mask_d = pix_bit;
                    if (pix_last) begin
                        emit      = 1'b1;
                        emit_addr = pix_addr;
                        emit_data = pix_data;
                        emit_mask = pix_bit;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (pix_ok && same_addr) begin
                    data_d = (data_q & ~pix_bit) | pix_data;
                    mask_d = mask_q | pix_bit;
                    if (pix_last || flush) begin
                        emit      = 1'b1;
                        emit_data = data_d;
                        emit_mask = mask_d;
                        state_d   = ST_IDLE;
                    end
                end else if (pix_ok) begin
                    // Held word leaves; the new pixel starts a fresh word, even if it is a last pixel.
                    emit   = 1'b1;
                    addr_d = pix_addr;
                    data_d = pix_data;
                    mask_d = pix_bit;
                end else if (flush) begin
                    emit    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            if (fifo_drop) overflow_q <= 1'b1;
        end
    end

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (emit),
        .pop_i   (word_ready),
        .data_i  ({emit_addr, emit_data, emit_mask}),
        .valid_o (word_valid),
        .head_o  ({word_addr, word_data, word_mask}),
        .drop_o  (fifo_drop)
    );

    assign overflow = overflow_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Scoreboard bench for pixel_packer: a pending-word reference model predicts emitted
// words and FIFO drops; a negedge monitor compares every word the DUT hands over.
module tb_pixel_packer;

    localparam int W     = 512;
    localparam int H     = 342;
    localparam int WW    = 16;
    localparam int WPL   = W / WW;
    localparam int DEPTH = 2;

    typedef struct {
        int          addr;
        logic [15:0] data;
        logic [15:0] mask;
    } word_t;

    logic        clk, reset;
    logic        pix_we, pix_val, flush, word_ready;
    logic [8:0]  pix_x, pix_y;
    logic        word_valid, overflow;
    logic [13:0] word_addr;
    logic [15:0] word_data, word_mask;

    int vectors     = 0;
    int miscompares = 0;

    word_t       exp_q[$];
    bit          p_valid;
    int          p_addr;
    logic [15:0] p_data, p_mask;
    int          m_count;
    bit          m_ovf;

    pixel_packer #(
        .OUTPUT_WIDTH  (W),
        .OUTPUT_HEIGHT (H),
        .WORD_W        (WW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_we     (pix_we),
        .pix_val    (pix_val),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .flush      (flush),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_addr  (word_addr),
        .word_data  (word_data),
        .word_mask  (word_mask),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: at most one pending word; a word leaves when its last pixel arrives,
    // when a pixel for another word arrives, or on flush.
    task automatic model_step(input bit we, input bit val, input int x, input int y,
                              input bit fl, input bit rdy);
        bit          ok, emitted, last, pop;
        int          a;
        logic [15:0] b;
        word_t       e;
        ok      = we && (x < W) && (y < H);
        a       = y * WPL + x / WW;
        b       = 16'h8000 >> (x % WW);
        last    = (x % WW) == WW - 1;
        pop     = (m_count > 0) && rdy;
        emitted = 0;
        if (ok && p_valid && a == p_addr) begin
            p_data = val ? (p_data | b) : (p_data & ~b);
            p_mask = p_mask | b;
            if (last || fl) begin
                e = '{p_addr, p_data, p_mask};
                emitted = 1;
                p_valid = 0;
            end
        end else if (ok) begin
            if (p_valid) begin
                e = '{p_addr, p_data, p_mask};
                emitted = 1;
            end
            p_addr  = a;
            p_data  = val ? b : 16'h0;
            p_mask  = b;
            p_valid = 1;
            if (last && !emitted) begin
                e = '{p_addr, p_data, p_mask};
                emitted = 1;
                p_valid = 0;
            end
        end else if (fl && p_valid) begin
            e = '{p_addr, p_data, p_mask};
            emitted = 1;
            p_valid = 0;
        end
        if (emitted) begin
            if (m_count < DEPTH || pop) begin
                exp_q.push_back(e);
                m_count++;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop) m_count--;
    endtask

    task automatic drive(input bit we, input bit val, input int x, input int y,
                         input bit fl, input bit rdy);
        pix_we     = we;
        pix_val    = val;
        pix_x      = 9'(x);
        pix_y      = 9'(y);
        flush      = fl;
        word_ready = rdy;
        model_step(we, val, x, y, fl, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, rdy);
    endtask

    task automatic full_word(input int y, input bit rdy_last);
        for (int i = 0; i < WW; i++)
            drive(1, 1'($urandom_range(0, 1)), i, y, 0, (i == WW - 1) ? rdy_last : 1'b0);
    endtask

    task automatic clear_model();
        p_valid = 0;
        m_count = 0;
        m_ovf   = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        pix_we = 0; pix_val = 0; pix_x = '0; pix_y = '0; flush = 0; word_ready = 0;
        reset = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        word_t e;
        if (!reset && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("word_addr", word_addr, e.addr);
                check("word_data", word_data, e.data);
                check("word_mask", word_mask, e.mask);
            end
        end
    end

    initial begin
        int x, y, valid_seen;
        reset = 1'b1;
        pix_we = 0; pix_val = 0; pix_x = '0; pix_y = '0; flush = 0; word_ready = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", word_valid, 0);
        check("rst_addr", word_addr, 0);
        check("rst_data", word_data, 0);
        check("rst_mask", word_mask, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;

        // Alternating row of 16 pixels forms one complete word.
        for (int i = 0; i < WW; i++) begin
            drive(1, 1'(i % 2 == 0), i, 0, 0, 1);
            if (i == WW - 2) check("row_not_early", word_valid, 0);
        end
        check("row_valid", word_valid, 1);
        check("row_addr", word_addr, 0);
        check("row_data", word_data, 16'hAAAA);
        check("row_mask", word_mask, 16'hFFFF);
        idle(1, 1);

        // Moving to another word emits the held partial word.
        drive(1, 1, 32, 1, 0, 1);
        drive(1, 1, 33, 1, 0, 1);
        drive(1, 1, 100, 1, 0, 1);
        check("switch_valid", word_valid, 1);
        check("switch_addr", word_addr, 1 * WPL + 2);
        check("switch_data", word_data, 16'hC000);
        check("switch_mask", word_mask, 16'hC000);
        drive(0, 0, 0, 0, 1, 1);
        idle(2, 1);

        // Flush of a single pixel on the last line; a second flush is a no-op.
        drive(1, 1, 5, H - 1, 0, 1);
        drive(0, 0, 0, 0, 1, 1);
        check("flush_addr", word_addr, (H - 1) * WPL);
        check("flush_data", word_data, 16'h0400);
        check("flush_mask", word_mask, 16'h0400);
        drive(0, 0, 0, 0, 1, 1);
        check("flush_twice", word_valid, 0);
        idle(1, 1);

        // Three words with the sink stalled: two queue, the third drops.
        full_word(2, 0);
        full_word(3, 0);
        full_word(4, 0);
        check("stall_overflow", overflow, 1);
        check("stall_valid", word_valid, 1);
        check("stall_head_addr", word_addr, exp_q[0].addr);
        check("stall_head_data", word_data, exp_q[0].data);
        check("stall_head_mask", word_mask, exp_q[0].mask);
        idle(3, 1);

        // Third word completes on the very cycle the head is popped: no drop.
        do_reset();
        full_word(8, 0);
        full_word(9, 0);
        full_word(10, 1);
        check("popfull_overflow", overflow, 0);
        idle(4, 1);

        // Reset mid-word with a queued word: outputs clear at once, nothing after release.
        do_reset();
        full_word(6, 0);
        for (int i = 0; i < 7; i++) drive(1, 1, i, 7, 0, 0);
        check("pre_rst_valid", word_valid, 1);
        reset = 1'b1;
        #1;
        check("midrst_valid", word_valid, 0);
        check("midrst_addr", word_addr, 0);
        check("midrst_data", word_data, 0);
        check("midrst_mask", word_mask, 0);
        do_reset();
        valid_seen = 0;
        drive(0, 0, 0, 0, 1, 1);
        if (word_valid) valid_seen++;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            if (word_valid) valid_seen++;
        end
        check("no_word_after_rst", valid_seen, 0);

        // Randomised raster-like traffic with back-pressure and flushes.
        do_reset();
        x = 0;
        y = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                x = x + 1;
                if (x == W) begin x = 0; y = (y + 1) % H; end
                drive(1, 1'($urandom_range(0, 1)), x, y, $urandom_range(0, 99) < 4,
                      $urandom_range(0, 99) < 70);
            end else if (r < 80) begin
                drive(1, 1'($urandom_range(0, 1)), x, y, $urandom_range(0, 99) < 4,
                      $urandom_range(0, 99) < 70);
            end else if (r < 88) begin
                x = int'($urandom_range(0, W - 1));
                y = int'($urandom_range(0, H - 1));
                drive(1, 1'($urandom_range(0, 1)), x, y, 0, $urandom_range(0, 99) < 70);
            end else if (r < 93) begin
                drive(1, 1, int'($urandom_range(0, W - 1)), int'($urandom_range(H, 511)),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 70);
            end else begin
                drive(0, 0, 0, 0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70);
            end
        end
        drive(0, 0, 0, 0, 1, 1);
        idle(6, 1);
        check("queue_drained", exp_q.size(), 0);
        check("rand_overflow", overflow, m_ovf);
        check("rand_valid_idle", word_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
